// File: rtl/debounce_sync_pkg.sv
// debounce_sync_pkg: shared state encoding and default debounce constants
package debounce_sync_pkg;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_W           = 3;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_t;

    function automatic logic is_high(state_t s);
        return (s == STABLE_HIGH) || (s == CHECK_LOW);
    endfunction

    function automatic logic is_checking(state_t s);
        return (s == CHECK_HIGH) || (s == CHECK_LOW);
    endfunction

endpackage

// File: rtl/debounce_sync_if.sv
// debounce_sync_if: raw input and conditioned outputs of the debouncer
interface debounce_sync_if;
    logic raw_in;
    logic dout;
    logic busy;
    modport master (output raw_in, input dout, input busy);
    modport slave  (input raw_in, output dout, output busy);
endinterface

// File: rtl/debounce_sync_sync_chain.sv
// sync_chain: plain flop chain bringing an asynchronous bit into the clk domain
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes a bouncy raw input and flips dout only after
// DEBOUNCE_CYCLES consecutive cycles at the opposite level
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            RESET_N,
    debounce_sync_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_sync_q;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (RESET_N),
        .i_d   (bus.raw_in),
        .o_q   (w_sync_q)
    );

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Defaults double as the glitch-reject and illegal-state recovery path
    always_comb begin
        w_state_nxt = STABLE_LOW;
        w_cnt_nxt   = '0;
        case (r_state)
            STABLE_LOW: begin
                w_state_nxt = w_sync_q ? CHECK_HIGH : STABLE_LOW;
                w_cnt_nxt   = w_sync_q ? CNT_ONE : '0;
            end
            CHECK_HIGH: begin
                if (w_sync_q) begin
                    w_state_nxt = (r_cnt == CNT_LAST) ? STABLE_HIGH : CHECK_HIGH;
                    w_cnt_nxt   = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                w_state_nxt = w_sync_q ? STABLE_HIGH : CHECK_LOW;
                w_cnt_nxt   = w_sync_q ? '0 : CNT_ONE;
            end
            CHECK_LOW: begin
                w_state_nxt = STABLE_HIGH;
                if (!w_sync_q) begin
                    w_state_nxt = (r_cnt == CNT_LAST) ? STABLE_LOW : CHECK_LOW;
                    w_cnt_nxt   = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = STABLE_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.dout = is_high(r_state);
    assign bus.busy = is_checking(r_state);
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed plus randomized checks of debounce_sync against a
// run-length reference model
module tb_debounce_sync;
    import debounce_sync_pkg::*;

    localparam int SS = DEF_SYNC_STAGES;
    localparam int DC = DEF_DEBOUNCE_CYCLES;

    logic clk = 1'b0;
    logic RESET_N = 1'b0;
    int checks = 0;
    int errors = 0;

    debounce_sync_if bus ();

    debounce_sync #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(DEF_CNT_W)) dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Model: sync_q is raw_in delayed SS edges; dout flips after DC consecutive
    // differing samples, and busy means a differing run is in progress
    bit m_q[$];
    bit m_dout;
    int m_run;

    always @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            m_q = {};
            for (int i = 0; i < SS; i++) m_q.push_back(1'b0);
            m_dout = 1'b0;
            m_run = 0;
        end else begin
            bit sq;
            sq = m_q.pop_front();
            m_q.push_back(bus.raw_in);
            if (sq != m_dout) begin
                m_run++;
                if (m_run == DC) begin
                    m_dout = !m_dout;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    task automatic check(string tag, logic got, logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("model_dout", bus.dout, m_dout);
        check("model_busy", bus.busy, m_run > 0);
    endtask

    task automatic hold(int n, logic v);
        bus.raw_in = v;
        repeat (n) tick();
    endtask

    initial begin
        int rise_edge;
        int len;
        logic v;

        // Reset with raw_in high: outputs low immediately and throughout
        bus.raw_in = 1'b1;
        #1;
        check("rst_now_dout", bus.dout, 1'b0);
        check("rst_now_busy", bus.busy, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("rst_dout", bus.dout, 1'b0);
            check("rst_busy", bus.busy, 1'b0);
        end
        bus.raw_in = 1'b0;
        RESET_N = 1'b1;
        hold(4, 1'b0);

        // Clean rise
        bus.raw_in = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("rise_busy", bus.busy, e >= 3 && e <= 5);
            check("rise_dout", bus.dout, e >= 6);
        end

        // Clean fall
        bus.raw_in = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("fall_busy", bus.busy, e >= 3 && e <= 5);
            check("fall_dout", bus.dout, e < 6);
        end

        // Glitch of three cycles
        bus.raw_in = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            if (e == 4) bus.raw_in = 1'b0;
            tick();
            check("glitch_busy", bus.busy, e >= 3 && e <= 5);
            check("glitch_dout", bus.dout, 1'b0);
        end

        // Bounce 1,0,1,0 then held 1
        hold(1, 1'b1);
        hold(1, 1'b0);
        hold(1, 1'b1);
        hold(1, 1'b0);
        bus.raw_in = 1'b1;
        rise_edge = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (bus.dout && rise_edge == 0) rise_edge = e;
            check("bounce_dout", bus.dout, e >= 6);
        end
        checks++;
        assert (rise_edge == 6) else begin
            errors++;
            $error("FAIL bounce_latency: observed %0d expected %0d", rise_edge, 6);
        end

        // Reset during CHECK_LOW
        bus.raw_in = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        check("pre_rst_dout", bus.dout, 1'b1);
        check("pre_rst_busy", bus.busy, 1'b1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("midrst_dout", bus.dout, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        @(negedge clk);
        bus.raw_in = 1'b1;
        RESET_N = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("post_rst_dout", bus.dout, e >= 6);
        end

        // Randomized levels and hold lengths with occasional resets
        for (int k = 0; k < 150; k++) begin
            v = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * DC + 1);
            if ($urandom_range(0, 39) == 0) begin
                RESET_N = 1'b0;
                tick();
                RESET_N = 1'b1;
            end
            hold(len, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
